// File: rtl/ov5640_rgb_capture.sv
// OV5640 DVP RGB565 capture: sensor xclk generation, oversampled pclk/sync/data, RGB888 video out.
// Pixel latency 3 core cycles from the sampled pclk rise of the low byte; no back-pressure (sensor-paced).
module ov5640_rgb_capture #(
  parameter int XCLK_DIV    = 4,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        cmos_clk_i,
  input  logic        rst_n_i,
  input  logic        cmos_pclk_i,
  input  logic        cmos_vsync_i,
  input  logic        cmos_href_i,
  input  logic [7:0]  cmos_data_i,
  output logic        cmos_xclk_o,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] rgb
);

  localparam int CW = (XCLK_DIV > 2) ? $clog2(XCLK_DIV) : 1;
  localparam int FW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [CW-1:0] XC_HALF = CW'(XCLK_DIV / 2 - 1);
  localparam logic [CW-1:0] XC_LAST = CW'(XCLK_DIV - 1);
  localparam logic [FW-1:0] FC_MAX  = FW'(SKIP_FRAMES);

  logic [CW-1:0] r_xclk_cnt;
  logic          r_xclk;

  logic          r_s1_pclk, r_s1_vsync, r_s1_href;
  logic [7:0]    r_s1_data;
  logic          r_s2_pclk, r_s2_vsync, r_s2_href;
  logic [7:0]    r_s2_data;
  logic          r_s3_pclk, r_s3_vsync, r_s3_href;

  logic [FW-1:0] r_frame_cnt;
  logic          r_phase;
  logic [7:0]    r_hi;
  logic [15:0]   r_pix;
  logic          r_pix_vld;

  logic          w_pclk_rise;
  logic          w_vs_rise;
  logic          w_en;

  assign w_pclk_rise = r_s2_pclk & ~r_s3_pclk;
  assign w_vs_rise   = r_s2_vsync & ~r_s3_vsync;
  assign w_en        = (r_frame_cnt == FC_MAX);
  assign cmos_xclk_o = r_xclk;

  always_ff @(posedge cmos_clk_i) begin
    if (!rst_n_i) begin
      r_xclk_cnt <= '0;
      r_xclk     <= 1'b0;
    end else begin
      r_xclk_cnt <= (r_xclk_cnt == XC_LAST) ? '0 : r_xclk_cnt + CW'(1);
      if (r_xclk_cnt == XC_HALF || r_xclk_cnt == XC_LAST)
        r_xclk <= ~r_xclk;
    end
  end

  // All sensor inputs share one two-flop chain so data stays aligned with its pclk edge.
  always_ff @(posedge cmos_clk_i) begin
    if (!rst_n_i) begin
      r_s1_pclk  <= 1'b0;
      r_s1_vsync <= 1'b0;
      r_s1_href  <= 1'b0;
      r_s1_data  <= '0;
      r_s2_pclk  <= 1'b0;
      r_s2_vsync <= 1'b0;
      r_s2_href  <= 1'b0;
      r_s2_data  <= '0;
      r_s3_pclk  <= 1'b0;
      r_s3_vsync <= 1'b0;
      r_s3_href  <= 1'b0;
    end else begin
      r_s1_pclk  <= cmos_pclk_i;
      r_s1_vsync <= cmos_vsync_i;
      r_s1_href  <= cmos_href_i;
      r_s1_data  <= cmos_data_i;
      r_s2_pclk  <= r_s1_pclk;
      r_s2_vsync <= r_s1_vsync;
      r_s2_href  <= r_s1_href;
      r_s2_data  <= r_s1_data;
      r_s3_pclk  <= r_s2_pclk;
      r_s3_vsync <= r_s2_vsync;
      r_s3_href  <= r_s2_href;
    end
  end

  always_ff @(posedge cmos_clk_i) begin
    if (!rst_n_i)
      r_frame_cnt <= '0;
    else if (w_vs_rise && !w_en)
      r_frame_cnt <= r_frame_cnt + FW'(1);
  end

  // vsync holds the pair phase at 0, so it beats a coincident pclk rise.
  always_ff @(posedge cmos_clk_i) begin
    if (!rst_n_i) begin
      r_phase   <= 1'b0;
      r_hi      <= '0;
      r_pix     <= '0;
      r_pix_vld <= 1'b0;
    end else begin
      r_pix_vld <= 1'b0;
      if (r_s2_vsync) begin
        r_phase <= 1'b0;
      end else if (w_pclk_rise) begin
        if (!r_s2_href) begin
          r_phase <= 1'b0;
        end else if (!r_phase) begin
          r_hi    <= r_s2_data;
          r_phase <= 1'b1;
        end else begin
          r_pix     <= {r_hi, r_s2_data};
          r_pix_vld <= 1'b1;
          r_phase   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge cmos_clk_i) begin
    if (!rst_n_i) begin
      vs_o <= 1'b0;
      hs_o <= 1'b0;
      de_o <= 1'b0;
      rgb  <= '0;
    end else begin
      vs_o <= r_s3_vsync & w_en;
      hs_o <= r_s3_href & w_en;
      de_o <= r_pix_vld & w_en;
      if (r_pix_vld && w_en)
        rgb <= {r_pix[15:11], r_pix[15:13],
                r_pix[10:5],  r_pix[10:9],
                r_pix[4:0],   r_pix[4:2]};
    end
  end

endmodule

// File: tb/tb_ov5640_rgb_capture.sv
// Directed bench for ov5640_rgb_capture: xclk, frame skipping, RGB expansion, odd lines, latency, mid-frame reset.
module tb_ov5640_rgb_capture;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        pclk  = 1'b0;
  logic        vsync = 1'b0;
  logic        href  = 1'b0;
  logic [7:0]  data  = 8'h00;
  logic        xclk;
  logic        vs;
  logic        hs;
  logic        de;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;

  int          de_cnt  = 0;
  int          vs_cyc  = 0;
  int          hs_cyc  = 0;
  int          cur_win = 0;
  logic        hs_prev = 1'b0;
  logic [23:0] rgb_q[$];
  int          win_q[$];

  logic [15:0] pix_tab [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410,
                               16'hFFFF, 16'h0000, 16'h1234, 16'hABCD};
  logic [23:0] exp_tab [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284,
                               24'hFFFFFF, 24'h000000, 24'h1045A5, 24'hAD796B};

  int b_de, b_vs, b_hs, b_rgb, b_win;

  ov5640_rgb_capture #(.XCLK_DIV(4), .SKIP_FRAMES(2)) dut (
    .cmos_clk_i   (clk),
    .rst_n_i      (rst_n),
    .cmos_pclk_i  (pclk),
    .cmos_vsync_i (vsync),
    .cmos_href_i  (href),
    .cmos_data_i  (data),
    .cmos_xclk_o  (xclk),
    .vs_o         (vs),
    .hs_o         (hs),
    .de_o         (de),
    .rgb          (rgb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (de) begin
      de_cnt++;
      rgb_q.push_back(rgb);
      if (hs) cur_win++;
    end
    if (vs) vs_cyc++;
    if (hs) hs_cyc++;
    if (hs_prev && !hs) begin
      win_q.push_back(cur_win);
      cur_win = 0;
    end
    hs_prev = hs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One byte per 4-cycle pclk period: 2 low (data changes), 2 high.
  task automatic send_byte(input logic [7:0] b, input logic h);
    @(negedge clk);
    pclk = 1'b0;
    data = b;
    href = h;
    @(negedge clk);
    @(negedge clk);
    pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_line(input int npix, input bit odd);
    logic [15:0] p;
    for (int i = 0; i < npix; i++) begin
      p = pix_tab[i % 8];
      send_byte(p[15:8], 1'b1);
      send_byte(p[7:0], 1'b1);
    end
    if (odd) send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
  endtask

  task automatic send_frame();
    for (int l = 0; l < 4; l++) send_line(8, 1'b0);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    repeat (8) @(negedge clk);
    vsync = 1'b0;
    idle(8);
  endtask

  task automatic take_base();
    b_de  = de_cnt;
    b_vs  = vs_cyc;
    b_hs  = hs_cyc;
    b_rgb = rgb_q.size();
    b_win = win_q.size();
  endtask

  initial begin
    idle(20);
    chk("rst_xclk", xclk, 0);
    chk("rst_vs", vs, 0);
    chk("rst_hs", hs, 0);
    chk("rst_de", de, 0);
    chk("rst_rgb", rgb, 0);

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("xclk_e1", xclk, 0);
    @(negedge clk) chk("xclk_e2", xclk, 1);
    @(negedge clk) chk("xclk_e3", xclk, 1);
    @(negedge clk) chk("xclk_e4", xclk, 0);
    @(negedge clk) chk("xclk_e5", xclk, 0);
    @(negedge clk) chk("xclk_e6", xclk, 1);

    // Frames 1 and 2 are swallowed by the skip counter.
    take_base();
    send_frame();
    vsync_pulse();
    send_frame();
    idle(6);
    chk("skip_de", de_cnt - b_de, 0);
    chk("skip_hs", hs_cyc - b_hs, 0);
    chk("skip_vs", vs_cyc - b_vs, 0);
    vsync_pulse();
    chk("en_vs_cycles", vs_cyc - b_vs, 8);

    take_base();
    send_frame();
    idle(6);
    chk("f3_de_count", de_cnt - b_de, 32);
    chk("f3_windows", win_q.size() - b_win, 4);
    for (int i = 0; i < 4; i++) chk("f3_win_pix", win_q[b_win + i], 8);
    for (int i = 0; i < 32; i++) chk("f3_rgb", rgb_q[b_rgb + i], exp_tab[i % 8]);
    chk("rgb_hold", rgb, 24'hAD796B);

    // 17-byte line followed by a normal line.
    take_base();
    send_line(8, 1'b1);
    send_line(8, 1'b0);
    idle(6);
    chk("odd_de_count", de_cnt - b_de, 16);
    chk("odd_win0", win_q[b_win], 8);
    chk("odd_win1", win_q[b_win + 1], 8);
    for (int i = 0; i < 16; i++) chk("odd_rgb", rgb_q[b_rgb + i], exp_tab[i % 8]);
    chk("odd_next_first", rgb_q[b_rgb + 8], 24'hFF0000);

    // Latency: href to hs_o, and low-byte pclk rise to de_o.
    idle(4);
    @(negedge clk);
    href = 1'b1;
    data = 8'hF8;
    pclk = 1'b0;
    @(negedge clk) chk("hs_lat_j0", hs, 0);
    @(negedge clk) begin chk("hs_lat_j1", hs, 0); pclk = 1'b1; end
    @(negedge clk) chk("hs_lat_j2", hs, 0);
    @(negedge clk) begin chk("hs_lat_j3", hs, 1); pclk = 1'b0; data = 8'h00; end
    @(negedge clk);
    @(negedge clk) pclk = 1'b1;
    @(negedge clk) chk("de_lat_k0", de, 0);
    @(negedge clk) begin chk("de_lat_k1", de, 0); pclk = 1'b0; end
    @(negedge clk) chk("de_lat_k2", de, 0);
    @(negedge clk) begin chk("de_lat_k3", de, 1); chk("de_lat_rgb", rgb, 24'hFF0000); end
    @(negedge clk) chk("de_lat_k4", de, 0);
    href = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(6);

    // Reset in the middle of an enabled line.
    send_byte(8'h07, 1'b1);
    send_byte(8'hE0, 1'b1);
    send_byte(8'h00, 1'b1);
    chk("hs_before_rst", hs, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_vs", vs, 0);
    chk("mid_rst_hs", hs, 0);
    chk("mid_rst_de", de, 0);
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_xclk", xclk, 0);
    href = 1'b0;
    pclk = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(4);

    take_base();
    send_line(8, 1'b0);
    idle(6);
    chk("re_skip1_de", de_cnt - b_de, 0);
    vsync_pulse();
    chk("re_skip1_vs", vs_cyc - b_vs, 0);
    send_line(8, 1'b0);
    idle(6);
    chk("re_skip2_de", de_cnt - b_de, 0);
    chk("re_skip2_hs", hs_cyc - b_hs, 0);
    vsync_pulse();
    chk("re_en_vs", vs_cyc - b_vs, 8);
    send_line(8, 1'b0);
    idle(6);
    chk("re_en_de", de_cnt - b_de, 8);
    chk("re_en_first", rgb_q[b_rgb], 24'hFF0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
